pwm_fade_ctrl: RTL

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_period_cnt.sv | 18 +
 rtl/pwm_fade_ctrl.sv | 87 ++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared duty width, fade FSM states and saturating duty step helpers
package pwm_pkg;
  localparam int DUTY_W = 8;
  typedef enum logic [2:0] {IDLE, RAMP_UP, HOLD_HIGH, RAMP_DOWN, HOLD_LOW} fade_state_t;
  // 9-bit sum so a large step saturates at lim instead of wrapping
  function automatic logic [DUTY_W-1:0] step_up(input logic [DUTY_W-1:0] d, input logic [DUTY_W-1:0] step, input logic [DUTY_W-1:0] lim);
    logic [DUTY_W:0] s;
    s = {1'b0, d} + {1'b0, step};
    return (s > {1'b0, lim}) ? lim : s[DUTY_W-1:0];
  endfunction
  // borrow bit flags underflow; either underflow or undershoot clamps to lim
  function automatic logic [DUTY_W-1:0] step_down(input logic [DUTY_W-1:0] d, input logic [DUTY_W-1:0] step, input logic [DUTY_W-1:0] lim);
    logic [DUTY_W:0] s;
    s = {1'b0, d} - {1'b0, step};
    return (s[DUTY_W] || s[DUTY_W-1:0] < lim) ? lim : s[DUTY_W-1:0];
  endfunction
endpackage

// File: rtl/pwm_period_cnt.sv
// pwm_period_cnt: counts PWM rollovers, flags the rollover that reaches term and self-clears
// ports: clk, rst_n (sync, active-low), clear, rollover, term (terminal count), reached (comb pulse)
module pwm_period_cnt
  import pwm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              rollover,
  input  logic [DUTY_W-1:0] term,
  output logic              reached
);
  logic [DUTY_W-1:0] cnt;
  assign reached = rollover && ({1'b0, cnt} + 9'd1 == {1'b0, term});
  always_ff @(posedge clk)
    if (!rst_n || clear || reached) cnt <= '0;
    else if (rollover) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: breathing-LED duty sequencer (ramp up, hold, ramp down, hold) paced by PWM rollovers
// ports: clk, rst_n (sync, active-low), enable, rollover, min_level, max_level -> duty_cycle, busy, cycle_done
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned STEP             = 1,
  parameter int unsigned PERIODS_PER_STEP = 4,
  parameter int unsigned HOLD_PERIODS     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              rollover,
  input  logic [DUTY_W-1:0] min_level,
  input  logic [DUTY_W-1:0] max_level,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              busy,
  output logic              cycle_done
);
  fade_state_t state, state_nx;
  logic [DUTY_W-1:0] lo, hi, lo_nx, hi_nx, duty_nx, eff_max, term;
  logic done_nx, hit;
  assign eff_max = (hi > lo) ? hi : lo;
  assign term = (state == RAMP_UP || state == RAMP_DOWN) ? DUTY_W'(PERIODS_PER_STEP) : DUTY_W'(HOLD_PERIODS);
  // counter held clear in IDLE so a rollover coincident with the start is never counted
  pwm_period_cnt u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state == IDLE),
    .rollover (rollover),
    .term     (term),
    .reached  (hit)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state      <= IDLE;
      duty_cycle <= '0;
      lo         <= '0;
      hi         <= '0;
      cycle_done <= 1'b0;
    end else begin
      state      <= state_nx;
      duty_cycle <= duty_nx;
      lo         <= lo_nx;
      hi         <= hi_nx;
      cycle_done <= done_nx;
    end
  always_comb begin
    state_nx = state;
    duty_nx  = duty_cycle;
    lo_nx    = lo;
    hi_nx    = hi;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        duty_nx = '0;
        if (enable) begin
          lo_nx    = min_level;
          hi_nx    = max_level;
          duty_nx  = min_level;
          state_nx = RAMP_UP;
        end
      end
      RAMP_UP: if (hit) begin
        duty_nx  = step_up(duty_cycle, DUTY_W'(STEP), eff_max);
        state_nx = (duty_nx == eff_max) ? HOLD_HIGH : RAMP_UP;
      end
      HOLD_HIGH: state_nx = hit ? RAMP_DOWN : HOLD_HIGH;
      RAMP_DOWN: if (hit) begin
        duty_nx  = step_down(duty_cycle, DUTY_W'(STEP), lo);
        state_nx = (duty_nx == lo) ? HOLD_LOW : RAMP_DOWN;
      end
      HOLD_LOW: if (hit) begin
        done_nx  = 1'b1;
        lo_nx    = enable ? min_level : lo;
        hi_nx    = enable ? max_level : hi;
        duty_nx  = enable ? min_level : '0;
        state_nx = enable ? RAMP_UP : IDLE;
      end
      default: begin
        state_nx = IDLE;
        duty_nx  = '0;
      end
    endcase
  end
  always_comb busy = (state != IDLE);
endmodule
